fp_result_collector: RTL and testbench

- Parametrised successor to the system-level output decoder. Collects results from N_UNITS floating-point units (add, mul, sine, …) in program order, as dictated by the unit tag at the head of the op FIFO.
- Buffers results in a DEPTH-entry first-word-fall-through FIFO read by the CPU.
- Adds over the previous generation: correct full/empty handling, explicit valid, flush, occupancy output and sticky error flags.

---
 rtl/fp_result_collector.sv | 164 ++++++++++++++++
 tb/tb_fp_result_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
// -----------------------------------------------------------------------------
// fp_result_collector
//
// Purpose:
//   Gathers results from N_UNITS floating-point functional units in program
//   order. The op FIFO head tag names the unit whose result comes next. A
//   result is captured only when that unit signals done, the output FIFO has
//   room, no serve is in flight and no flush is requested. Captured results
//   go into a DEPTH-entry first-word-fall-through FIFO that the CPU reads.
//
// Ports:
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   unit_result   unit i result on bits [i*DATA_W +: DATA_W]
//   unit_done     unit i result ready, held until served
//   op_valid      op FIFO head is valid
//   op_tag        unit index of the op FIFO head
//   cpu_pop       CPU consumes the current FIFO head
//   flush         synchronous clear of the output FIFO and pending serve
//   result        FIFO head data (zero while empty)
//   result_valid  FIFO non-empty
//   out_fifo_full FIFO holds DEPTH entries
//   count         current occupancy
//   unit_serv     one-cycle acknowledge to the served unit
//   op_fifo_pop   one-cycle pop to the op FIFO (OR of unit_serv)
//   err_underflow sticky: cpu_pop while empty
//   err_badtag    sticky: op_valid with an out-of-range op_tag
// -----------------------------------------------------------------------------
module fp_result_collector #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int N_UNITS = 3,
  parameter int TAG_W   = 2
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [N_UNITS*DATA_W-1:0]     unit_result,
  input  logic [N_UNITS-1:0]            unit_done,
  input  logic                          op_valid,
  input  logic [TAG_W-1:0]              op_tag,
  input  logic                          cpu_pop,
  input  logic                          flush,
  output logic [DATA_W-1:0]             result,
  output logic                          result_valid,
  output logic                          out_fifo_full,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [N_UNITS-1:0]            unit_serv,
  output logic                          op_fifo_pop,
  output logic                          err_underflow,
  output logic                          err_badtag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_pending;
  logic [N_UNITS-1:0] r_serv;
  logic               r_opop;
  logic               r_err_uf;
  logic               r_err_bt;

  logic               w_tag_ok;
  logic               w_done_sel;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_pop;

  // Select the done flag and result slice of the unit named by the op head.
  always_comb begin
    w_done_sel = 1'b0;
    w_sel_data = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (op_tag == TAG_W'(i)) begin
        w_done_sel = unit_done[i];
        w_sel_data = unit_result[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_tag_ok = (int'(op_tag) < N_UNITS);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);

  // Capture is blocked while a serve pulse is out (r_pending), so a unit that
  // still holds done during its acknowledge cycle is not captured twice.
  assign w_accept = op_valid && w_tag_ok && w_done_sel && !w_full &&
                    !r_pending && !flush;
  assign w_pop    = cpu_pop && !w_empty && !flush;

  // Storage is data only; it needs no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_sel_data;
    end
  end

  // Control state: pointers, occupancy, serve handshake and sticky errors.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_serv    <= '0;
      r_opop    <= 1'b0;
      r_err_uf  <= 1'b0;
      r_err_bt  <= 1'b0;
    end else begin
      if (cpu_pop && w_empty) begin
        r_err_uf <= 1'b1;
      end
      if (op_valid && !w_tag_ok) begin
        r_err_bt <= 1'b1;
      end

      if (flush) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_pending <= 1'b0;
        r_serv    <= '0;
        r_opop    <= 1'b0;
      end else begin
        // Pending lasts exactly the cycle in which the serve pulse is high.
        r_pending <= w_accept;
        r_opop    <= w_accept;
        for (int i = 0; i < N_UNITS; i++) begin
          r_serv[i] <= w_accept && (op_tag == TAG_W'(i));
        end

        // DEPTH is a power of two, so pointer wrap is natural overflow.
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end

        case ({w_accept, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign result        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign result_valid  = !w_empty;
  assign out_fifo_full = w_full;
  assign count         = r_count;
  assign unit_serv     = r_serv;
  assign op_fifo_pop   = r_opop;
  assign err_underflow = r_err_uf;
  assign err_badtag    = r_err_bt;

endmodule

// File: tb/tb_fp_result_collector.sv
module tb_fp_result_collector;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int N_UNITS = 3;
  localparam int TAG_W   = 2;

  localparam logic [31:0] U0 = 32'h3F800000;
  localparam logic [31:0] U1 = 32'h40490FDB;
  localparam logic [31:0] U2 = 32'hC0000000;

  logic                       clk;
  logic                       n_rst;
  logic [N_UNITS*DATA_W-1:0]  unit_result;
  logic [N_UNITS-1:0]         unit_done;
  logic                       op_valid;
  logic [TAG_W-1:0]           op_tag;
  logic                       cpu_pop;
  logic                       flush;
  logic [DATA_W-1:0]          result;
  logic                       result_valid;
  logic                       out_fifo_full;
  logic [3:0]                 count;
  logic [N_UNITS-1:0]         unit_serv;
  logic                       op_fifo_pop;
  logic                       err_underflow;
  logic                       err_badtag;

  int n_chk  = 0;
  int n_fail = 0;

  fp_result_collector #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .N_UNITS(N_UNITS), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .n_rst(n_rst), .unit_result(unit_result), .unit_done(unit_done),
    .op_valid(op_valid), .op_tag(op_tag), .cpu_pop(cpu_pop), .flush(flush),
    .result(result), .result_valid(result_valid), .out_fifo_full(out_fifo_full),
    .count(count), .unit_serv(unit_serv), .op_fifo_pop(op_fifo_pop),
    .err_underflow(err_underflow), .err_badtag(err_badtag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [1:0]  tag;
    logic [2:0]  done;
    logic        pop;
    logic        fl;
    logic [2:0]  e_serv;
    logic        e_opop;
    logic [3:0]  e_cnt;
    logic        e_vld;
    logic [31:0] e_res;
    logic        e_uf;
    logic        e_bt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_u0(input logic [31:0] v);
    unit_result[0 +: DATA_W] = v;
  endtask

  logic [31:0] base;
  logic        seen;

  initial begin
    // Applied inputs, then outputs expected after the following clock edge.
    //           ov  tag   done    pop  fl   serv    opop cnt vld res  uf   bt
    tbl[0]  = '{1'b1,2'd1,3'b010,1'b0,1'b0,3'b010,1'b1,4'd1,1'b1,U1,1'b0,1'b0};
    tbl[1]  = '{1'b1,2'd1,3'b010,1'b0,1'b0,3'b000,1'b0,4'd1,1'b1,U1,1'b0,1'b0};
    tbl[2]  = '{1'b0,2'd0,3'b000,1'b0,1'b0,3'b000,1'b0,4'd1,1'b1,U1,1'b0,1'b0};
    tbl[3]  = '{1'b1,2'd2,3'b101,1'b0,1'b0,3'b100,1'b1,4'd2,1'b1,U1,1'b0,1'b0};
    tbl[4]  = '{1'b1,2'd2,3'b101,1'b0,1'b0,3'b000,1'b0,4'd2,1'b1,U1,1'b0,1'b0};
    tbl[5]  = '{1'b1,2'd0,3'b001,1'b0,1'b0,3'b001,1'b1,4'd3,1'b1,U1,1'b0,1'b0};
    tbl[6]  = '{1'b0,2'd0,3'b000,1'b0,1'b0,3'b000,1'b0,4'd3,1'b1,U1,1'b0,1'b0};
    tbl[7]  = '{1'b0,2'd0,3'b000,1'b1,1'b0,3'b000,1'b0,4'd2,1'b1,U2,1'b0,1'b0};
    tbl[8]  = '{1'b0,2'd0,3'b000,1'b1,1'b0,3'b000,1'b0,4'd1,1'b1,U0,1'b0,1'b0};
    tbl[9]  = '{1'b0,2'd0,3'b000,1'b1,1'b0,3'b000,1'b0,4'd0,1'b0,32'h0,1'b0,1'b0};
    tbl[10] = '{1'b0,2'd0,3'b000,1'b0,1'b0,3'b000,1'b0,4'd0,1'b0,32'h0,1'b0,1'b0};
    tbl[11] = '{1'b0,2'd0,3'b000,1'b1,1'b0,3'b000,1'b0,4'd0,1'b0,32'h0,1'b1,1'b0};
    tbl[12] = '{1'b0,2'd0,3'b000,1'b0,1'b0,3'b000,1'b0,4'd0,1'b0,32'h0,1'b1,1'b0};
    tbl[13] = '{1'b1,2'd3,3'b111,1'b0,1'b0,3'b000,1'b0,4'd0,1'b0,32'h0,1'b1,1'b1};
    tbl[14] = '{1'b0,2'd0,3'b000,1'b0,1'b0,3'b000,1'b0,4'd0,1'b0,32'h0,1'b1,1'b1};

    unit_result = {U2, U1, U0};
    unit_done   = '0;
    op_valid    = 1'b0;
    op_tag      = '0;
    cpu_pop     = 1'b0;
    flush       = 1'b0;
    n_rst       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst count", 32'(count), 32'd0);
    chk("rst valid", 32'(result_valid), 32'd0);
    chk("rst result", result, 32'h0);
    chk("rst serv", 32'(unit_serv), 32'd0);
    chk("rst opop", 32'(op_fifo_pop), 32'd0);
    chk("rst errs", {30'd0, err_underflow, err_badtag}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    chk("idle count", 32'(count), 32'd0);
    chk("idle full", 32'(out_fifo_full), 32'd0);

    // Table: single capture, program-order capture, pops, error flags.
    for (int i = 0; i < 15; i++) begin
      op_valid  = tbl[i].ov;
      op_tag    = tbl[i].tag;
      unit_done = tbl[i].done;
      cpu_pop   = tbl[i].pop;
      flush     = tbl[i].fl;
      step();
      chk($sformatf("row%0d serv", i), 32'(unit_serv), 32'(tbl[i].e_serv));
      chk($sformatf("row%0d opop", i), 32'(op_fifo_pop), 32'(tbl[i].e_opop));
      chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d valid", i), 32'(result_valid), 32'(tbl[i].e_vld));
      chk($sformatf("row%0d full", i), 32'(out_fifo_full), 32'(tbl[i].e_cnt == 4'd8));
      chk($sformatf("row%0d result", i), result, tbl[i].e_res);
      chk($sformatf("row%0d uf", i), 32'(err_underflow), 32'(tbl[i].e_uf));
      chk($sformatf("row%0d bt", i), 32'(err_badtag), 32'(tbl[i].e_bt));
    end
    op_valid = 1'b0; unit_done = '0; cpu_pop = 1'b0;

    // Fill to full from pointer position 3 so both pointers wrap.
    base = 32'hA0000000;
    for (int k = 0; k < 8; k++) begin
      set_u0(base + 32'(k));
      op_valid = 1'b1; op_tag = 2'd0; unit_done = 3'b001;
      step();
      chk($sformatf("fill%0d serv", k), 32'(unit_serv), 32'b001);
      chk($sformatf("fill%0d count", k), 32'(count), 32'(k + 1));
      step();
      chk($sformatf("fill%0d noserv", k), 32'(unit_serv), 32'b000);
    end
    chk("full flag", 32'(out_fifo_full), 32'd1);
    set_u0(base + 32'd8);
    repeat (3) begin
      step();
      chk("ninth blocked serv", 32'(unit_serv), 32'b000);
      chk("ninth blocked count", 32'(count), 32'd8);
    end
    chk("head before pop", result, base);
    cpu_pop = 1'b1;
    step();
    cpu_pop = 1'b0;
    chk("pop at full serv", 32'(unit_serv), 32'b000);
    chk("pop at full count", 32'(count), 32'd7);
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      step();
      if (unit_serv == 3'b001) seen = 1'b1;
    end
    chk("ninth served", 32'(seen), 32'd1);
    chk("ninth count", 32'(count), 32'd8);
    op_valid = 1'b0; unit_done = '0;
    step();
    for (int k = 1; k < 9; k++) begin
      chk($sformatf("drain%0d", k), result, base + 32'(k));
      cpu_pop = 1'b1;
      step();
      cpu_pop = 1'b0;
    end
    chk("drained count", 32'(count), 32'd0);
    chk("drained valid", 32'(result_valid), 32'd0);

    // Flush while a capture is lined up, keeping the sticky errors.
    for (int k = 0; k < 3; k++) begin
      set_u0(32'hB0000000 + 32'(k));
      op_valid = 1'b1; op_tag = 2'd0; unit_done = 3'b001;
      step();
      if (k < 2) step();
    end
    chk("preflush count", 32'(count), 32'd3);
    chk("preflush serv", 32'(unit_serv), 32'b001);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush count", 32'(count), 32'd0);
    chk("flush valid", 32'(result_valid), 32'd0);
    chk("flush serv", 32'(unit_serv), 32'b000);
    chk("flush opop", 32'(op_fifo_pop), 32'd0);
    chk("flush uf kept", 32'(err_underflow), 32'd1);
    chk("flush bt kept", 32'(err_badtag), 32'd1);
    // Pending was cleared by flush, so the still-held done is captured now.
    set_u0(32'hC1000000);
    step();
    chk("postflush serv", 32'(unit_serv), 32'b001);
    chk("postflush result", result, 32'hC1000000);
    step();
    // Simultaneous capture and pop leaves count unchanged.
    set_u0(32'hC2000000);
    cpu_pop = 1'b1;
    step();
    cpu_pop = 1'b0;
    chk("wr+pop count", 32'(count), 32'd1);
    chk("wr+pop result", result, 32'hC2000000);
    op_valid = 1'b0; unit_done = '0;
    step();

    // Reset in the middle of a serve pulse drops it without a clock edge.
    op_valid = 1'b1; op_tag = 2'd1; unit_done = 3'b010;
    step();
    chk("preRst serv", 32'(unit_serv), 32'b010);
    n_rst = 1'b0;
    #1;
    chk("asyncRst serv", 32'(unit_serv), 32'b000);
    chk("asyncRst opop", 32'(op_fifo_pop), 32'd0);
    chk("asyncRst count", 32'(count), 32'd0);
    chk("asyncRst errs", {30'd0, err_underflow, err_badtag}, 32'd0);
    op_valid = 1'b0; unit_done = '0;
    @(negedge clk);
    n_rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
